// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud divider helper
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  // Rounded clocks per oversample tick, never below one.
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    int div;
    div = (clk_hz + (baud * os) / 2) / (baud * os);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider with phase restart
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST) && !restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver with valid/ready byte output
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ_HZ = 50_000_000,
  parameter int      BAUD_RATE   = 115200,
  parameter int      OVERSAMPLE  = 16,
  parameter int      DATA_BITS   = 8,
  parameter parity_e PARITY_MODE = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID_A   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] MID_B   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] MID_C   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] BIT_END = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);

  logic                 rx_meta, rx_sync;
  logic [1:0]           fill;
  logic                 armed;
  rx_state_e            state;
  logic [SW-1:0]        s_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp_a, samp_b, par_bit;
  logic                 pend, pend_fe, pend_pe;
  logic                 tick, start_det, mid, bit_end, bit_val, par_ones, parity_bad;

  // fill marks when rx_sync carries the real line, so a line low out of reset never arms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      fill    <= 2'b00;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      fill    <= {fill[0], 1'b1};
    end
  end

  assign start_det = (state == IDLE) && armed && !rx_sync;
  assign mid       = tick && (s_cnt == MID_C);
  assign bit_end   = tick && (s_cnt == BIT_END);
  assign bit_val   = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
  assign par_ones  = ^{shreg, par_bit};

  always_comb begin
    parity_bad = 1'b0;
    if (PARITY_MODE == PAR_EVEN)     parity_bad = par_ones;
    else if (PARITY_MODE == PAR_ODD) parity_bad = !par_ones;
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_det),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      armed        <= 1'b0;
      s_cnt        <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      samp_a       <= 1'b1;
      samp_b       <= 1'b1;
      par_bit      <= 1'b0;
      pend         <= 1'b0;
      pend_fe      <= 1'b0;
      pend_pe      <= 1'b0;
      busy_o       <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      pend      <= 1'b0;
      if (tick && state != IDLE) begin
        s_cnt <= bit_end ? '0 : s_cnt + SW'(1);
        if (s_cnt == MID_A) samp_a <= rx_sync;
        if (s_cnt == MID_B) samp_b <= rx_sync;
      end
      case (state)
        IDLE: begin
          // Consuming armed on start means a new start always needs the line seen high first.
          if (start_det) begin
            state  <= START;
            armed  <= 1'b0;
            s_cnt  <= '0;
            busy_o <= 1'b1;
          end else if (rx_sync && fill[1]) begin
            armed <= 1'b1;
          end
        end
        START: begin
          if (mid && bit_val) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (mid) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) state <= (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        PARITY: begin
          if (mid) par_bit <= bit_val;
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (mid) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            pend    <= 1'b1;
            pend_fe <= !bit_val;
            pend_pe <= parity_bad;
          end
        end
        default: state <= IDLE;
      endcase
      if (pend) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o    <= shreg;
          frame_err_o  <= pend_fe;
          parity_err_o <= pend_pe;
          rx_valid_o   <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule
